// File: rtl/stopwatch_core_if.sv
// Button-level inputs and time/status outputs of the stopwatch timing stage.
// The master side drives the buttons and the slave side is the stopwatch core.
interface stopwatch_core_if;
    logic        start_stop_btn;
    logic        clear_btn;
    logic        lap_btn;
    logic [38:0] time_out;
    logic        running;
    logic        lap_hold;
    logic        saturated;

    modport master (
        output start_stop_btn, clear_btn, lap_btn,
        input  time_out, running, lap_hold, saturated
    );

    modport slave (
        input  start_stop_btn, clear_btn, lap_btn,
        output time_out, running, lap_hold, saturated
    );
endinterface

// File: rtl/stopwatch_core.sv
// Stopwatch timing stage: counts 10 ns ticks under a run/pause/saturate FSM.
// Lap hold is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_core #(
    parameter logic [38:0] TICK_STEP = 39'd1,
    parameter logic [38:0] MAX_COUNT = 39'd539999999999
) (
    input  logic             clk,
    input  logic             rst,
    stopwatch_core_if.slave  sw
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_SAT} state_t;

`ifdef STOPWATCH_LAP_EN
    localparam int NUM_BTN = 3;
`else
    localparam int NUM_BTN = 2;
`endif

    state_t               r_state, w_state_next;
    logic [38:0]          r_count, w_count_next;
    logic [39:0]          w_sum;
    logic [NUM_BTN-1:0]   w_btn, r_btn_prev, w_btn_edge;
    logic                 w_ss_edge, w_clr_edge;
    logic                 w_lap_hold;
    logic [38:0]          w_display;

    logic [38:0]          r_time_out;
    logic                 r_running, r_lap_hold_out, r_saturated;

`ifdef STOPWATCH_LAP_EN
    assign w_btn = {sw.lap_btn, sw.clear_btn, sw.start_stop_btn};
`else
    assign w_btn = {sw.clear_btn, sw.start_stop_btn};
`endif

    // Prev registers start high so a button held through reset gives no edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_btn_prev <= '1;
        else     r_btn_prev <= w_btn;
    end

    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_edge
            assign w_btn_edge[gi] = w_btn[gi] & ~r_btn_prev[gi];
        end
    endgenerate

    assign w_ss_edge  = w_btn_edge[0];
    assign w_clr_edge = w_btn_edge[1];
    assign w_sum      = {1'b0, r_count} + {1'b0, TICK_STEP};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
        end
    end

    // Saturation wins over a stop press in the same cycle; clear wins over all.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        case (r_state)
            S_IDLE:  if (w_ss_edge) w_state_next = S_RUN;
            S_RUN: begin
                if (w_sum >= {1'b0, MAX_COUNT}) begin
                    w_count_next = MAX_COUNT;
                    w_state_next = S_SAT;
                end else begin
                    w_count_next = w_sum[38:0];
                    if (w_ss_edge) w_state_next = S_PAUSE;
                end
            end
            S_PAUSE: if (w_ss_edge) w_state_next = S_RUN;
            S_SAT:   w_count_next = MAX_COUNT;
            default: w_state_next = S_IDLE;
        endcase
        if (w_clr_edge) begin
            w_state_next = S_IDLE;
            w_count_next = '0;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic        r_lap_hold, w_lap_hold_next;
    logic [38:0] r_lap_reg;
    logic        w_lap_ok;

    assign w_lap_ok = w_btn_edge[2] & ((r_state == S_RUN) | (r_state == S_PAUSE));

    always_comb begin
        w_lap_hold_next = r_lap_hold;
        if (w_clr_edge)    w_lap_hold_next = 1'b0;
        else if (w_lap_ok) w_lap_hold_next = ~r_lap_hold;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lap_hold <= 1'b0;
            r_lap_reg  <= '0;
        end else begin
            r_lap_hold <= w_lap_hold_next;
            if (w_lap_ok && !r_lap_hold && !w_clr_edge) r_lap_reg <= r_count;
        end
    end

    assign w_lap_hold = r_lap_hold;
    assign w_display  = r_lap_hold ? r_lap_reg : r_count;
`else
    assign w_lap_hold = 1'b0;
    assign w_display  = r_count;
`endif

    // Output stage is registered, so every output trails internal state by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_time_out     <= '0;
            r_running      <= 1'b0;
            r_lap_hold_out <= 1'b0;
            r_saturated    <= 1'b0;
        end else begin
            r_time_out     <= w_display;
            r_running      <= (r_state == S_RUN);
            r_lap_hold_out <= w_lap_hold;
            r_saturated    <= (r_state == S_SAT);
        end
    end

    assign sw.time_out  = r_time_out;
    assign sw.running   = r_running;
    assign sw.lap_hold  = r_lap_hold_out;
    assign sw.saturated = r_saturated;
endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: directed scenarios plus random button traffic,
// checked each cycle against a behavioural model of the stopwatch.
module tb_stopwatch_core;
    localparam longint MAXC    = 64'd539999999999;
    localparam longint SAT_MAX = 64'd300;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_SAT = 3;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    typedef struct { longint cnt; int mode; longint lapv; bit hold; bit pss; bit pcl; bit plp; } ms_t;
    typedef struct { longint t; bit run; bit hold; bit sat; } mo_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ss = 1'b0, cl = 1'b0, lp = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    ms_t  mm, mx;
    mo_t  em, ex;

    stopwatch_core_if mif ();
    stopwatch_core_if sif ();
    assign mif.start_stop_btn = ss;
    assign mif.clear_btn      = cl;
    assign mif.lap_btn        = lp;
    assign sif.start_stop_btn = ss;
    assign sif.clear_btn      = cl;
    assign sif.lap_btn        = lp;

    stopwatch_core dut (.clk(clk), .rst(rst), .sw(mif));
    stopwatch_core #(.TICK_STEP(39'd1), .MAX_COUNT(39'd300)) dut_sat (.clk(clk), .rst(rst), .sw(sif));

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic ms_t m_reset();
        ms_t s;
        s.cnt = 0; s.mode = M_IDLE; s.lapv = 0; s.hold = 1'b0;
        s.pss = 1'b1; s.pcl = 1'b1; s.plp = 1'b1;
        return s;
    endfunction

    function automatic mo_t m_out(ms_t s);
        mo_t o;
        o.t    = s.hold ? s.lapv : s.cnt;
        o.run  = (s.mode == M_RUN);
        o.hold = s.hold;
        o.sat  = (s.mode == M_SAT);
        return o;
    endfunction

    // One clock of stopwatch behaviour from the button levels seen at that edge.
    function automatic ms_t m_step(ms_t s, bit b_ss, bit b_cl, bit b_lp, longint stepv, longint maxv);
        ms_t n = s;
        bit e_ss = b_ss && !s.pss;
        bit e_cl = b_cl && !s.pcl;
        bit e_lp = b_lp && !s.plp;
        n.pss = b_ss; n.pcl = b_cl; n.plp = b_lp;
        if (e_cl) begin
            n.cnt = 0; n.mode = M_IDLE; n.hold = 1'b0;
            return n;
        end
        if (s.mode == M_RUN) begin
            if (s.cnt + stepv >= maxv) begin
                n.cnt = maxv; n.mode = M_SAT;
            end else begin
                n.cnt = s.cnt + stepv;
                if (e_ss) n.mode = M_PAUSE;
            end
        end else if ((s.mode == M_IDLE || s.mode == M_PAUSE) && e_ss) begin
            n.mode = M_RUN;
        end
        if (LAP_EN && e_lp && (s.mode == M_RUN || s.mode == M_PAUSE)) begin
            if (s.hold) n.hold = 1'b0;
            else begin n.hold = 1'b1; n.lapv = s.cnt; end
        end
        return n;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_range(input string nm, input logic [63:0] act, input longint lo, input longint hi);
        n_tests++;
        if ($isunknown(act) || act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic chk_outs();
        chk("main.time_out",  mif.time_out,  em.t);
        chk("main.running",   mif.running,   em.run);
        chk("main.lap_hold",  mif.lap_hold,  em.hold);
        chk("main.saturated", mif.saturated, em.sat);
        chk("sat.time_out",   sif.time_out,  ex.t);
        chk("sat.running",    sif.running,   ex.run);
        chk("sat.lap_hold",   sif.lap_hold,  ex.hold);
        chk("sat.saturated",  sif.saturated, ex.sat);
    endtask

    // Advance one clock: model steps at the rising edge, outputs compared at the falling edge.
    task automatic cyc();
        @(posedge clk);
        if (rst) begin
            mm = m_reset(); mx = m_reset();
            em = m_out(mm); ex = m_out(mx);
        end else begin
            em = m_out(mm); ex = m_out(mx);
            mm = m_step(mm, ss, cl, lp, 1, MAXC);
            mx = m_step(mx, ss, cl, lp, 1, SAT_MAX);
        end
        @(negedge clk);
        chk_outs();
    endtask

    task automatic press_ss();
        ss = 1'b1; cyc(); ss = 1'b0; cyc();
    endtask

    task automatic do_clear();
        cl = 1'b1; cyc(); cl = 1'b0; cyc();
    endtask

    task automatic run_until(input longint target, input string nm);
        int guard = 0;
        while (mm.cnt != target && guard < 20000) begin
            cyc();
            guard++;
        end
        chk(nm, mm.cnt, target);
    endtask

    initial begin
        mm = m_reset(); mx = m_reset();
        em = m_out(mm); ex = m_out(mx);
        cyc(); cyc();
        chk("reset.time_out", mif.time_out, 0);
        chk("reset.running", mif.running, 0);
        rst = 1'b0;
        cyc(); cyc();

        // Start latency: edge N -> running after N+1, first tick after N+2.
        ss = 1'b1; cyc();
        chk("lat.running_N", mif.running, 0);
        ss = 1'b0; cyc();
        chk("lat.running_N1", mif.running, 1);
        chk("lat.time_N1", mif.time_out, 0);
        cyc();
        chk("lat.time_N2", mif.time_out, 1);
        repeat (10000) cyc();
        press_ss(); cyc();
        chk("stop.running", mif.running, 0);
        chk_range("stop.time", mif.time_out, 10000, 10010);
        chk("sat.value", sif.time_out, 300);
        chk("sat.flag", sif.saturated, 1);
        repeat (1000) cyc();
        chk_range("hold.time", mif.time_out, 10000, 10010);
        chk("sat.press_ignored", sif.running, 0);
        chk("sat.still_300", sif.time_out, 300);

        // Async reset mid-run at count 1234, start button held through it.
        do_clear(); press_ss();
        run_until(1234, "rst.model_at_1234");
        #1 rst = 1'b1; ss = 1'b1;
        #1;
        chk("arst.time_out", mif.time_out, 0);
        chk("arst.running", mif.running, 0);
        chk("arst.sat_flag", sif.saturated, 0);
        cyc(); cyc();
        rst = 1'b0;
        cyc(); cyc(); cyc();
        chk("held.no_run", mif.running, 0);
        ss = 1'b0; cyc();
        ss = 1'b1; cyc(); cyc(); cyc();
        chk("held.rerun", mif.running, 1);
        ss = 1'b0; cyc();

        // Clear and start/stop edges together while running at 500.
        do_clear(); press_ss();
        run_until(500, "clr.model_at_500");
        cl = 1'b1; ss = 1'b1; cyc();
        cl = 1'b0; ss = 1'b0; cyc();
        chk("clr.running", mif.running, 0);
        chk("clr.time_out", mif.time_out, 0);

`ifdef STOPWATCH_LAP_EN
        press_ss();
        run_until(2000, "lap.model_at_2000");
        lp = 1'b1; cyc(); lp = 1'b0; cyc();
        chk("lap.hold", mif.lap_hold, 1);
        chk("lap.time", mif.time_out, 2000);
        chk("lap.running", mif.running, 1);
        repeat (5000) cyc();
        lp = 1'b1; cyc(); lp = 1'b0; cyc();
        chk("lap.release", mif.lap_hold, 0);
        chk_range("lap.live", mif.time_out, 7000, 7010);
`endif

        // Random button traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) ss = ~ss;
            if ($urandom_range(0, 11) == 0) lp = ~lp;
            cl = ($urandom_range(0, 149) == 0);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
